// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, strobes and key codes
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    ONE,
    MULTI
  } frame_res_e;

  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [3:0] COL_0 = 4'b0111;
  localparam logic [3:0] COL_1 = 4'b1011;
  localparam logic [3:0] COL_2 = 4'b1101;
  localparam logic [3:0] COL_3 = 4'b1110;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_SPACE = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  function automatic logic [3:0] col_strobe(
    input logic [1:0] col
  );
    logic [3:0] s;
    unique case (col)
      2'd0: s = COL_0;
      2'd1: s = COL_1;
      2'd2: s = COL_2;
      2'd3: s = COL_3;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] key_map(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] k;
    unique case ({row, col})
      4'h0: k = KEY_1;
      4'h1: k = KEY_2;
      4'h2: k = KEY_3;
      4'h3: k = KEY_C;
      4'h4: k = KEY_4;
      4'h5: k = KEY_5;
      4'h6: k = KEY_6;
      4'h7: k = KEY_D;
      4'h8: k = KEY_7;
      4'h9: k = KEY_8;
      4'hA: k = KEY_9;
      4'hB: k = KEY_E;
      4'hC: k = KEY_STAR;
      4'hD: k = KEY_0;
      4'hE: k = KEY_SPACE;
      4'hF: k = KEY_F;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad lines and key event
// outputs between the scanner and its host.
interface keypad_scan_ctrl_if;
  logic       scan_en;
  logic [3:0] linha;
  logic [3:0] coluna;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_multi;

  modport master (
    output scan_en,
    output linha,
    input  coluna,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  key_multi
  );

  modport slave (
    input  scan_en,
    input  linha,
    output coluna,
    output key_code,
    output key_valid,
    output key_held,
    output key_multi
  );
endinterface

// File: rtl/keypad_frame_acc.sv
// keypad_frame_acc: holds one row sample per column
// and classifies the completed frame.
module keypad_frame_acc
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       smp_en,
  input  logic [1:0] col,
  input  logic [3:0] linha,
  output logic       done,
  output frame_res_e res,
  output logic [3:0] code
);

  logic [3:0][3:0] smp;
  logic [1:0]      hits;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      smp  <= '1;
      done <= 1'b0;
    end else begin
      done <= smp_en && (col == 2'd3);
      if (smp_en) begin
        smp[col] <= linha;
      end
    end
  end

  // hits saturates at 2: anything past one press is MULTI
  always_comb begin
    hits = 2'd0;
    code = KEY_0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!smp[c][3-r]) begin
          code = key_map(2'(r), 2'(c));
          if (hits != 2'd2) begin
            hits = hits + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    unique case (hits)
      2'd0:    res = NONE;
      2'd1:    res = ONE;
      default: res = MULTI;
    endcase
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scanner with frame-level
// press/release debounce for a 4x4 keypad.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  keypad_scan_ctrl_if.slave kif
);

  localparam logic [15:0] DWELL_LAST =
    16'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DB_N =
    4'(DEBOUNCE_SCANS);

  logic        run;
  logic [15:0] dwell;
  logic [1:0]  col;
  state_e      state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [3:0]  cand;
  logic [3:0]  code_q;
  logic        valid_q;
  logic        held_q;
  logic        multi_q;

  logic        smp_en;
  logic        done;
  frame_res_e  res;
  logic [3:0]  code;

  assign smp_en = run && (dwell == DWELL_LAST);
  assign cnt_nx = cnt + 4'd1;

  keypad_frame_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (!kif.scan_en),
    .smp_en (smp_en),
    .col    (col),
    .linha  (kif.linha),
    .done   (done),
    .res    (res),
    .code   (code)
  );

  // run lags scan_en by one cycle so col 0 starts
  // on the cycle after enable, with dwell at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      run     <= 1'b0;
      dwell   <= '0;
      col     <= '0;
      state   <= SCAN;
      cnt     <= '0;
      cand    <= '0;
      code_q  <= KEY_0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      if (!kif.scan_en) begin
        run    <= 1'b0;
        dwell  <= '0;
        col    <= '0;
        state  <= SCAN;
        cnt    <= '0;
        held_q <= 1'b0;
      end else begin
        run <= 1'b1;
        if (run) begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            col   <= col + 2'd1;
          end else begin
            dwell <= dwell + 16'd1;
          end
        end
        if (done) begin
          unique case (state)
            SCAN: begin
              if (res == ONE) begin
                cand <= code;
                if (DB_N == 4'd1) begin
                  code_q  <= code;
                  valid_q <= 1'b1;
                  held_q  <= 1'b1;
                  state   <= HELD;
                end else begin
                  cnt   <= 4'd1;
                  state <= DEBOUNCE;
                end
              end else if (res == MULTI) begin
                multi_q <= 1'b1;
              end
            end
            DEBOUNCE: begin
              if (res == ONE && code == cand) begin
                if (cnt_nx == DB_N) begin
                  code_q  <= cand;
                  valid_q <= 1'b1;
                  held_q  <= 1'b1;
                  cnt     <= '0;
                  state   <= HELD;
                end else begin
                  cnt <= cnt_nx;
                end
              end else begin
                cnt     <= '0;
                state   <= SCAN;
                multi_q <= (res == MULTI);
              end
            end
            HELD: begin
              if (res == NONE) begin
                if (DB_N == 4'd1) begin
                  held_q <= 1'b0;
                  state  <= SCAN;
                end else begin
                  cnt   <= 4'd1;
                  state <= RELEASE;
                end
              end
            end
            RELEASE: begin
              if (res == NONE) begin
                if (cnt_nx == DB_N) begin
                  held_q <= 1'b0;
                  cnt    <= '0;
                  state  <= SCAN;
                end else begin
                  cnt <= cnt_nx;
                end
              end else begin
                cnt   <= '0;
                state <= HELD;
              end
            end
            default: state <= SCAN;
          endcase
        end
      end
    end
  end

  assign kif.coluna    = run ? col_strobe(col)
                             : COL_IDLE;
  assign kif.key_code  = code_q;
  assign kif.key_valid = valid_q;
  assign kif.key_held  = held_q;
  assign kif.key_multi = multi_q;

endmodule
